// File: rtl/store_ot_pkg.sv
// Shared types and constants for the store outstanding-transaction tracker.
// Watchdog logic in the tracker is enabled by defining STORE_OT_TIMEOUT_EN.
package store_ot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        ACK   = 2'd2
    } state_e;

    localparam int MAX_OUTSTANDING_STORES = 7;

    function automatic int cnt_width(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/store_ot_id_table.sv
// Per-AXI-ID outstanding store counters with a nonzero lookup used to
// decide whether a B response matches an in-flight store.
module store_ot_id_table
    import store_ot_pkg::*;
#(
    parameter int IdWidth  = 4,
    parameter int CntWidth = cnt_width(MAX_OUTSTANDING_STORES)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               inc_i,
    input  logic [IdWidth-1:0] inc_id_i,
    input  logic               dec_i,
    input  logic [IdWidth-1:0] dec_id_i,
    input  logic [IdWidth-1:0] lookup_id_i,
    output logic               nonzero_o
);

    localparam int NumIds = 2 ** IdWidth;

    logic [CntWidth-1:0] cnt_q [NumIds];
    logic [CntWidth-1:0] cnt_d [NumIds];

    // Same-ID inc and dec cancel; different IDs move independently.
    always_comb begin
        for (int i = 0; i < NumIds; i++) begin
            cnt_d[i] = cnt_q[i];
            if (inc_i && (inc_id_i == IdWidth'(i))) begin
                cnt_d[i] = cnt_d[i] + CntWidth'(1);
            end
            if (dec_i && (dec_id_i == IdWidth'(i))) begin
                cnt_d[i] = cnt_d[i] - CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumIds; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumIds; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign nonzero_o = (cnt_q[lookup_id_i] != '0);

endmodule

// File: rtl/store_ot_tracker.sv
// Bounds in-flight AXI write stores, checks B IDs and serves fence drains.
// Optional watchdog enabled by defining STORE_OT_TIMEOUT_EN.
module store_ot_tracker
    import store_ot_pkg::*;
#(
    parameter int MaxOutstanding = MAX_OUTSTANDING_STORES,
    parameter int IdWidth        = 4,
    parameter int CntWidth       = cnt_width(MaxOutstanding),
    parameter int TimeoutCycles  = 1024
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [IdWidth-1:0]  issue_id_i,
    input  logic                retire_valid_i,
    input  logic [IdWidth-1:0]  retire_id_i,
    input  logic                fence_req_i,
    output logic                fence_ack_o,
    output logic [CntWidth-1:0] outstanding_o,
    output logic                empty_o,
    output logic                err_o,
    output logic                timeout_o
);

    if (MaxOutstanding < 1 || TimeoutCycles < 1) begin : g_bad_cfg
        $error("store_ot_tracker: MaxOutstanding and TimeoutCycles must be >= 1");
    end

    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

    state_e              state_q;
    logic [CntWidth-1:0] count_q;
    logic [CntWidth-1:0] count_d;
    logic                err_q;
    logic                id_live;
    logic                issue_fire;
    logic                retire_ok;

    assign issue_ready_o = (state_q == IDLE) && (count_q < MaxCnt)
                           && !fence_req_i;
    assign issue_fire    = issue_valid_i & issue_ready_o;
    assign retire_ok     = retire_valid_i & id_live;

    store_ot_id_table #(
        .IdWidth  (IdWidth),
        .CntWidth (CntWidth)
    ) u_id_table (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .inc_i       (issue_fire),
        .inc_id_i    (issue_id_i),
        .dec_i       (retire_ok),
        .dec_id_i    (retire_id_i),
        .lookup_id_i (retire_id_i),
        .nonzero_o   (id_live)
    );

    always_comb begin
        count_d = count_q;
        unique case ({issue_fire, retire_ok})
            2'b10:   count_d = count_q + CntWidth'(1);
            2'b01:   count_d = count_q - CntWidth'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            if (retire_valid_i && !id_live) begin
                err_q <= 1'b1;
            end
        end
    end

    // Fence FSM works off the registered count only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (fence_req_i) begin
                        state_q <= (count_q == '0) ? ACK : DRAIN;
                    end
                end
                DRAIN: begin
                    if (count_q == '0) begin
                        state_q <= ACK;
                    end
                end
                ACK:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fence_ack_o   = (state_q == ACK);
    assign outstanding_o = count_q;
    assign empty_o       = (count_q == '0);
    assign err_o         = err_q;

`ifdef STORE_OT_TIMEOUT_EN
    localparam int WdWidth = $clog2(TimeoutCycles + 1);
    localparam logic [WdWidth-1:0] WdMax = WdWidth'(TimeoutCycles);

    logic [WdWidth-1:0] wd_q;
    logic [WdWidth-1:0] wd_d;
    logic               timeout_q;

    always_comb begin
        wd_d = wd_q;
        if ((count_q == '0) || retire_ok) begin
            wd_d = '0;
        end else if (wd_q != WdMax) begin
            wd_d = wd_q + WdWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            if (wd_d == WdMax) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: doc/store_ot_tracker.md
Name: store_ot_tracker

Overview:
- Tracks outstanding AXI write transactions between the write-through dcache store path and the AXI adapter.
- Bounds in-flight stores to the configured maximum, which is 7 in the FPGA configuration.
- Checks each B response against the ID it returns on and flags responses that match no outstanding store.
- Services fence/drain requests with a req/ack handshake once every outstanding store has retired.

Parameters:
- MaxOutstanding, 7: maximum number of in-flight write transactions; must be at least 1.
- IdWidth, 4: AXI ID width; there are 2**IdWidth per-ID counters.
- CntWidth, $clog2(MaxOutstanding+1): width of the global counter and of each per-ID counter.
- TimeoutCycles, 1024: watchdog limit; used only when STORE_OT_TIMEOUT_EN is defined.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- issue_valid_i  in  1  store unit wants to issue an AW
- issue_ready_o  out  1  issue permitted this cycle
- issue_id_i  in  IdWidth  AXI ID of the issued store
- retire_valid_i  in  1  B handshake completed (b_valid & b_ready)
- retire_id_i  in  IdWidth  B response ID
- fence_req_i  in  1  drain request; level, held until ack
- fence_ack_o  out  1  single-cycle pulse: all stores retired
- outstanding_o  out  CntWidth  current global count
- empty_o  out  1  outstanding_o == 0
- err_o  out  1  sticky: retire with no matching outstanding store
- timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset values:
  - global count 0 and all per-ID counters 0.
  - state IDLE.
  - fence_ack_o=0, err_o=0, timeout_o=0, empty_o=1.
- Issue fires when issue_valid_i & issue_ready_o.
  - issue_ready_o = (state==IDLE) & (count < MaxOutstanding) & !fence_req_i.
  - Combinational from registered state and count, plus fence_req_i.
- Retire fires when retire_valid_i is high. It is accepted in every state; retire cannot be back-pressured.
- Retire is legal only if cnt[retire_id_i] != 0.
  - Illegal retire sets err_o the next cycle.
  - Illegal retire decrements neither the global nor the per-ID counter.
- Counter update, registered, one-cycle latency to outstanding_o:
  - Issue only: +1 on the global counter and on cnt[issue_id_i].
  - Legal retire only: -1 on the global counter and on cnt[retire_id_i].
  - Issue and legal retire in the same cycle: global counter unchanged.
  - Issue and legal retire in the same cycle, same ID: per-ID counter unchanged.
  - Issue and legal retire in the same cycle, different IDs: per-ID counters move independently.
- No wrap-around:
  - The global counter never exceeds MaxOutstanding because issue is gated.
  - Per-ID counters are bounded by the global counter.
- FSM states: IDLE, DRAIN, ACK.
  - IDLE -> ACK when fence_req_i & count==0.
  - IDLE -> DRAIN when fence_req_i & count!=0.
  - DRAIN -> ACK when count==0, using the registered count.
  - ACK: fence_ack_o=1 for exactly this one cycle, then -> IDLE.
  - Requester drops fence_req_i in the cycle after ack. If it is still high in IDLE, a new fence begins.
- issue_ready_o is 0 in DRAIN and ACK.
- err_o and timeout_o clear only on reset.
- Reset asserted mid-drain: state returns to IDLE and all counts clear; no ack is produced.

Optional Feature:
- Macro: STORE_OT_TIMEOUT_EN.
- Defined:
  - Watchdog counter, width $clog2(TimeoutCycles+1).
  - Increments each cycle with count!=0 and no legal retire.
  - Clears on any legal retire or when count==0.
  - Reaching TimeoutCycles sets timeout_o; the counter saturates.
- Not defined: no watchdog logic; timeout_o tied to 0.

Decomposition:
- Package store_ot_pkg holds:
  - FSM enum state_e {IDLE, DRAIN, ACK}.
  - Function cnt_width(max) returning $clog2(max+1).
  - Default constant MAX_OUTSTANDING_STORES = 7.
- One sub-module, store_ot_id_table:
  - 2**IdWidth per-ID counters with inc/dec ports.
  - Provides a legal-retire (nonzero) lookup for retire_id_i.
- The top level holds the global counter, the FSM and the watchdog.

Test Plan:
- Issue 7 stores, IDs 0..6, back-to-back -> outstanding_o=7; issue_ready_o=0 on the 8th attempt; one retire ID 3 -> issue_ready_o=1 next cycle.
- Issue ID 5 and retire ID 5 in the same cycle with count=3 -> outstanding_o stays 3 and cnt[5] is unchanged.
- Retire ID 9 with cnt[9]=0, count=2 -> err_o=1 next cycle; outstanding_o stays 2; err_o stays high until rst_i.
- Count=2, assert fence_req_i -> DRAIN, issue_ready_o=0; retire twice -> fence_ack_o pulses exactly one cycle after count reaches 0.
- Count=0, assert fence_req_i -> fence_ack_o high the following cycle; no DRAIN cycle.
- With STORE_OT_TIMEOUT_EN and TimeoutCycles=16: one issue, no retire -> timeout_o=1 after 16 cycles. Reset asserted mid-DRAIN -> state IDLE, outstanding_o=0, fence_ack_o never pulses.
